// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB requester arbiter: FSM encoding,
// completion status codes and the camera device address.
package sccb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_XFER  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ACK     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam logic [7:0] CAM_ADDR = 8'hC0;

endpackage

// File: rtl/sccb_arbiter_rr_pick.sv
// Combinational round-robin picker: returns a one-hot winner, searching
// from the index after last_i and wrapping around.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int PW    = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    last_i,
    output logic [N_REQ-1:0] win_o
);

    logic found_s;

    // Walk the requesters in priority order starting after the last winner.
    always_comb begin
        win_o   = '0;
        found_s = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!found_s && req_i[j] && (j == ((int'(last_i) + k) % N_REQ))) begin
                    win_o[j] = 1'b1;
                    found_s  = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

endmodule

// File: rtl/sccb_arbiter.sv
// Shares one SCCB master between N_REQ requesters. A round-robin winner's
// command is latched onto the master port, the transfer is tracked through
// the master's busy flag, and completion (or timeout) is reported with a
// one-cycle done pulse plus read data and status.
module sccb_arbiter
    import sccb_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_addr,
    input  logic [8*N_REQ-1:0]   req_sub_addr,
    input  logic [8*N_REQ-1:0]   req_data_wr,
    input  logic [N_REQ-1:0]     req_rw,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic [7:0]           rd_data,
    output logic [1:0]           err,
    output logic                 ena,
    output logic [7:0]           addr,
    output logic [7:0]           sub_addr,
    output logic [7:0]           data_wr,
    output logic                 rw,
    input  logic                 busy,
    input  logic                 ack_err,
    input  logic [7:0]           data_rd
);

    localparam int           PW       = (N_REQ > 2) ? 2 : 1;
    localparam logic [31:0]  TO_LAST  = 32'(TIMEOUT_CYC - 1);
    localparam logic [PW-1:0] LAST_RST = PW'(N_REQ - 1);

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               ena_q, ena_d;
    logic               rw_q, rw_d;
    logic [7:0]         addr_q, addr_d;
    logic [7:0]         sub_q, sub_d;
    logic [7:0]         wdat_q, wdat_d;
    logic [7:0]         rd_q, rd_d;
    logic [1:0]         err_q, err_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [PW-1:0]      last_q, last_d;

    logic [N_REQ-1:0]   win_s;
    logic [7:0]         sel_addr_s, sel_sub_s, sel_wdat_s;
    logic               sel_rw_s;
    logic [PW-1:0]      last_idx_s;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req_i  (req),
        .last_i (last_q),
        .win_o  (win_s)
    );

    // Mux the winner's command fields and encode the current owner's index.
    always_comb begin
        sel_addr_s = 8'h00;
        sel_sub_s  = 8'h00;
        sel_wdat_s = 8'h00;
        sel_rw_s   = 1'b0;
        last_idx_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_addr_s = sel_addr_s | ({8{win_s[i]}} & req_addr[8*i +: 8]);
            sel_sub_s  = sel_sub_s  | ({8{win_s[i]}} & req_sub_addr[8*i +: 8]);
            sel_wdat_s = sel_wdat_s | ({8{win_s[i]}} & req_data_wr[8*i +: 8]);
            sel_rw_s   = sel_rw_s   | (win_s[i] & req_rw[i]);
            last_idx_s = last_idx_s | ({PW{gnt_q[i]}} & PW'(i));
        end
    end

    // Next-state and registered-output logic for the arbitration FSM.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        ena_d   = ena_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        sub_d   = sub_q;
        wdat_d  = wdat_q;
        rd_d    = rd_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        last_d  = last_q;

        case (state_q)
            ST_IDLE: begin
                if ((|req) && !busy) begin
                    gnt_d   = win_s;
                    ena_d   = 1'b1;
                    addr_d  = sel_addr_s;
                    sub_d   = sel_sub_s;
                    wdat_d  = sel_wdat_s;
                    rw_d    = sel_rw_s;
                    cnt_d   = 32'd0;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d = cnt_q + 32'd1;
                if (busy) begin
                    ena_d   = 1'b0;
                    state_d = ST_XFER;
                end else if (cnt_q >= TO_LAST) begin
                    ena_d   = 1'b0;
                    err_d   = ERR_TIMEOUT;
                    done_d  = gnt_q;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_XFER: begin
                cnt_d = cnt_q + 32'd1;
                if (!busy) begin
                    rd_d    = data_rd;
                    err_d   = ack_err ? ERR_ACK : ERR_OK;
                    done_d  = gnt_q;
                    state_d = ST_DONE;
                end else if (cnt_q >= TO_LAST) begin
                    ena_d   = 1'b0;
                    err_d   = ERR_TIMEOUT;
                    done_d  = gnt_q;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_DONE: begin
                gnt_d   = '0;
                last_d  = last_idx_s;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                ena_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            ena_q   <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= 8'h00;
            sub_q   <= 8'h00;
            wdat_q  <= 8'h00;
            rd_q    <= 8'h00;
            err_q   <= ERR_OK;
            cnt_q   <= 32'd0;
            last_q  <= LAST_RST;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            ena_q   <= ena_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            sub_q   <= sub_d;
            wdat_q  <= wdat_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign ena      = ena_q;
    assign rw       = rw_q;
    assign addr     = addr_q;
    assign sub_addr = sub_q;
    assign data_wr  = wdat_q;
    assign rd_data  = rd_q;
    assign err      = err_q;

endmodule

// File: tb/tb_sccb_arbiter.sv
// Scoreboard bench for sccb_arbiter: a requester model predicts grant order
// round-robin, a behavioural SCCB master answers commands, and a monitor
// checks every done pulse against the expected queue.
module tb_sccb_arbiter;
    import sccb_pkg::*;

    localparam int N  = 2;
    localparam int TO = 100;

    typedef struct { int idx; logic [7:0] a; logic [7:0] s; logic [7:0] d; logic rw; } cmd_t;
    typedef struct { int idx; logic [7:0] rd; logic [1:0] err; bit chk_rd; } dn_t;
    typedef struct { logic [7:0] rd; logic ack; } rsp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_addr = '0;
    logic [8*N-1:0] req_sub_addr = '0;
    logic [8*N-1:0] req_data_wr = '0;
    logic [N-1:0]   req_rw = '0;
    logic [N-1:0]   gnt, done;
    logic [7:0]     rd_data, addr, sub_addr, data_wr;
    logic [1:0]     err;
    logic           ena, rw;
    logic           busy = 1'b0;
    logic           ack_err = 1'b0;
    logic [7:0]     data_rd = 8'h00;

    int checks = 0;
    int errors = 0;

    cmd_t cmd_q[$];
    dn_t  dn_q[$];
    rsp_t rsp_q[$];

    bit   mst_mute = 1'b0;
    bit   mst_hang = 1'b0;

    // requester-side model state
    logic [N-1:0] pend = '0;
    int           mlast = N - 1;
    logic [7:0]   m_rd = 8'h00;
    logic [7:0]   fa [N];
    logic [7:0]   fs [N];
    logic [7:0]   fd [N];
    logic         frw [N];
    logic [7:0]   rrd [N];
    logic         rack [N];

    sccb_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
        .req_sub_addr(req_sub_addr), .req_data_wr(req_data_wr), .req_rw(req_rw),
        .gnt(gnt), .done(done), .rd_data(rd_data), .err(err), .ena(ena),
        .addr(addr), .sub_addr(sub_addr), .data_wr(data_wr), .rw(rw),
        .busy(busy), .ack_err(ack_err), .data_rd(data_rd)
    );

    always #5 clk = ~clk;

    task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    function automatic int rr_next(input logic [N-1:0] p, input int last);
        for (int k = 1; k <= N; k++) begin
            if (p[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic push_expect(input int w);
        if (!mst_mute) begin
            cmd_q.push_back('{w, fa[w], fs[w], fd[w], frw[w]});
            rsp_q.push_back('{rrd[w], rack[w]});
            dn_q.push_back('{w, rrd[w], rack[w] ? 2'd1 : 2'd0, 1'b1});
            m_rd = rrd[w];
        end else begin
            dn_q.push_back('{w, m_rd, 2'd2, 1'b1});
        end
    endtask

    task automatic kick();
        int w;
        w = rr_next(pend, mlast);
        if (w >= 0) push_expect(w);
    endtask

    task automatic raise(input int i, input logic [7:0] a, input logic [7:0] s, input logic [7:0] d,
                         input logic rwv, input logic [7:0] rdv, input logic ackv);
        fa[i] = a; fs[i] = s; fd[i] = d; frw[i] = rwv; rrd[i] = rdv; rack[i] = ackv;
        req_addr[8*i +: 8] = a;
        req_sub_addr[8*i +: 8] = s;
        req_data_wr[8*i +: 8] = d;
        req_rw[i] = rwv;
        pend[i] = 1'b1;
        req[i] = 1'b1;
    endtask

    task automatic raise_rand(input int i);
        raise(i, ($urandom_range(0, 1) == 1) ? CAM_ADDR : 8'($urandom), 8'($urandom), 8'($urandom),
              1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
    endtask

    // Serve until nothing is pending; a finished requester may re-request at once.
    task automatic run_idle(input int rearm, input bit frc, input int budget);
        int n = 0;
        int left = rearm;
        while (pend != '0 && n < budget) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < N; i++) begin
                if (gnt[i] && !done[i]) begin
                    req_addr[8*i +: 8] = 8'($urandom);
                    req_sub_addr[8*i +: 8] = 8'($urandom);
                    req_data_wr[8*i +: 8] = 8'($urandom);
                    req_rw[i] = 1'($urandom);
                end
            end
            if (done != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (done[i] && pend[i]) begin
                        pend[i] = 1'b0;
                        req[i] = 1'b0;
                        mlast = i;
                        if (left > 0 && (frc || $urandom_range(0, 1) == 1)) begin
                            left--;
                            raise_rand(i);
                        end
                    end
                end
                kick();
            end
        end
        if (pend != '0) chkv("round_budget", 32'(pend), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chkv({tag, "_gnt"}, 32'(gnt), 32'd0);
        chkv({tag, "_done"}, 32'(done), 32'd0);
        chkv({tag, "_ena"}, 32'(ena), 32'd0);
        chkv({tag, "_rw"}, 32'(rw), 32'd0);
        chkv({tag, "_addr"}, 32'(addr), 32'd0);
        chkv({tag, "_sub"}, 32'(sub_addr), 32'd0);
        chkv({tag, "_wdat"}, 32'(data_wr), 32'd0);
        chkv({tag, "_rd"}, 32'(rd_data), 32'd0);
        chkv({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Monitor: every done pulse must match the head of the expected queue.
    always @(negedge clk) begin : mon
        dn_t e;
        logic [N-1:0] m;
        if (!rst) begin
            chkv("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
            if (done != '0) begin
                if (dn_q.size() == 0) begin
                    chkv("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = dn_q.pop_front();
                    m = '0;
                    m[e.idx] = 1'b1;
                    chkv("done_idx", 32'(done), 32'(m));
                    chkv("gnt_at_done", 32'(gnt), 32'(m));
                    chkv("err", 32'(err), 32'(e.err));
                    if (e.chk_rd) chkv("rd_data", 32'(rd_data), 32'(e.rd));
                end
            end
        end
    end

    // Behavioural SCCB master: accepts ena, raises busy, answers at busy fall.
    always begin : mst
        cmd_t c;
        rsp_t r;
        logic [N-1:0] m;
        int dly;
        int g;
        bit hung;
        @(negedge clk);
        if (!mst_mute && !rst && ena && !busy) begin
            if (cmd_q.size() == 0 || rsp_q.size() == 0) begin
                chkv("unexpected_cmd", 32'(gnt), 32'd0);
            end else begin
                c = cmd_q.pop_front();
                r = rsp_q.pop_front();
                m = '0;
                m[c.idx] = 1'b1;
                chkv("cmd_gnt", 32'(gnt), 32'(m));
                chkv("cmd_addr", 32'(addr), 32'(c.a));
                chkv("cmd_sub", 32'(sub_addr), 32'(c.s));
                chkv("cmd_wdat", 32'(data_wr), 32'(c.d));
                chkv("cmd_rw", 32'(rw), 32'(c.rw));
                dly = $urandom_range(0, 2);
                repeat (dly) @(negedge clk);
                busy = 1'b1;
                hung = mst_hang;
                g = 0;
                while (mst_hang && g < 2000) begin
                    @(negedge clk);
                    g++;
                end
                repeat ($urandom_range(1, 4)) @(negedge clk);
                if (!hung) begin
                    chkv("hold_addr", 32'(addr), 32'(c.a));
                    chkv("hold_sub", 32'(sub_addr), 32'(c.s));
                    chkv("hold_wdat", 32'(data_wr), 32'(c.d));
                    chkv("hold_rw", 32'(rw), 32'(c.rw));
                    chkv("ena_low_in_xfer", 32'(ena), 32'd0);
                end
                data_rd = r.rd;
                ack_err = r.ack;
                busy = 1'b0;
                @(negedge clk);
                ack_err = 1'b0;
                data_rd = 8'($urandom);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        repeat (3) @(negedge clk);
        check_reset_vals("rst0");
        rst = 1'b0;
        @(negedge clk);

        // contention from reset: both held, grants alternate 0,1,0,1...
        raise(0, CAM_ADDR, 8'h20, 8'h01, 1'b0, 8'h00, 1'b0);
        raise(1, CAM_ADDR, 8'h21, 8'h02, 1'b0, 8'h00, 1'b0);
        kick();
        run_idle(4, 1'b1, 600);

        // single write with grant latency check
        raise(0, CAM_ADDR, 8'h11, 8'h04, 1'b0, 8'h00, 1'b0);
        kick();
        @(negedge clk);
        chkv("gnt_latency", 32'(gnt), 32'd1);
        chkv("ena_latency", 32'(ena), 32'd1);
        run_idle(0, 1'b0, 200);

        // read returning 76
        raise(1, CAM_ADDR, 8'h0A, 8'h00, 1'b1, 8'h76, 1'b0);
        kick();
        run_idle(0, 1'b0, 200);

        // NACK, then a normal transfer
        raise(0, CAM_ADDR, 8'h12, 8'h34, 1'b0, 8'h55, 1'b1);
        kick();
        run_idle(0, 1'b0, 200);
        raise(0, CAM_ADDR, 8'h13, 8'h35, 1'b0, 8'h56, 1'b0);
        kick();
        run_idle(0, 1'b0, 200);

        // randomized rounds
        for (int rnd = 0; rnd < 30; rnd++) begin
            logic [N-1:0] mask;
            mask = N'($urandom_range(1, 3));
            for (int i = 0; i < N; i++) if (mask[i]) raise_rand(i);
            kick();
            run_idle($urandom_range(0, 3), 1'b0, 600);
        end

        // timeout: master never answers
        mst_mute = 1'b1;
        raise(0, CAM_ADDR, 8'h44, 8'h45, 1'b0, 8'h00, 1'b0);
        kick();
        n = 0;
        while (gnt == '0 && n < 20) begin @(negedge clk); n++; end
        chkv("to_gnt", 32'(gnt), 32'd1);
        chkv("to_ena_high", 32'(ena), 32'd1);
        n = 0;
        while (done == '0 && n < 300) begin @(negedge clk); n++; end
        chkv("to_cycles", 32'(n), 32'(TO));
        chkv("to_ena_low", 32'(ena), 32'd0);
        pend[0] = 1'b0;
        req[0] = 1'b0;
        mlast = 0;
        @(negedge clk);
        mst_mute = 1'b0;
        repeat (3) @(negedge clk);

        // reset during XFER while the master stays busy
        mst_hang = 1'b1;
        raise(1, CAM_ADDR, 8'h66, 8'h67, 1'b0, 8'h99, 1'b0);
        kick();
        n = 0;
        while (!(busy && !ena && gnt != '0) && n < 50) begin @(negedge clk); n++; end
        chkv("hang_reached_xfer", 32'(busy && !ena), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_mid");
        rst = 1'b0;
        dn_q.delete();
        mlast = N - 1;
        m_rd = 8'h00;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chkv("no_gnt_while_busy", 32'(gnt), 32'd0);
            chkv("no_done_after_rst", 32'(done), 32'd0);
        end
        kick();
        mst_hang = 1'b0;
        run_idle(0, 1'b0, 300);

        chkv("queues_empty", 32'(dn_q.size() + cmd_q.size() + rsp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
